mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//  Shares the single synchronous word memory between the core's instruction-fetch port (I) and load/store port (D).
//  Round-robin arbitration; at most one memory access is issued per cycle.
//  Read data returns one cycle after the grant and is routed back to the requester that issued the access.
//  Sits between the RISC-V core state machine and the MEM array / block RAM in SOC.
// PARAMETERS
//  MEM_DEPTH  256  memory size in 32-bit words; power of two
//  ADDR_W     32   width of the requester byte addresses
// PORTS
//  clk       in   1          system clock; all state updates on posedge
//  reset     in   1          asynchronous, active-low reset
//  i_req     in   1          fetch request; held high until i_gnt
//  i_addr    in   ADDR_W     fetch byte address; bits [1:0] are ignored
//  i_gnt     out  1          one-cycle pulse: fetch access issued this cycle
//  i_rvalid  out  1          one-cycle pulse: i_rdata valid
//  i_rdata   out  32         fetch read data
//  d_req     in   1          load/store request; held high until d_gnt
//  d_we      in   1          1 = store, 0 = load
//  d_wmask   in   4          byte enables for stores; bit n enables byte n
//  d_addr    in   ADDR_W     load/store byte address; bits [1:0] are ignored
//  d_wdata   in   32         store data
//  d_gnt     out  1          one-cycle pulse: data access issued this cycle
//  d_rvalid  out  1          one-cycle pulse, loads only: d_rdata valid
//  d_rdata   out  32         load read data
//  d_err     out  1          pulses with d_gnt+1 when d_addr is out of range
//  mem_en    out  1          memory access enable
//  mem_wmask out  4          byte write enables; 0 = read
//  mem_addr  out  AW         word index, AW = $clog2(MEM_DEPTH)
//  mem_wdata out  32         memory write data
//  mem_rdata in   32         memory read data; valid the cycle after mem_en
// BEHAVIOUR
//  Reset values: every output is 0; rr_last = I, so D wins the first tie; resp_owner = NONE.
//  Grant path is combinational in cycle T:
//   - i_gnt / d_gnt and the mem_* outputs are driven from i_req / d_req in the same cycle.
//   - Exactly one grant is given per cycle when any request is present.
//  Tie-break: when both requests are high, grant the port that is not rr_last.
//   - A lone requester is always granted, so back-to-back grants to one port are legal.
//   - rr_last updates to the granted port on every grant.
//  Word index and range check:
//   - Word index = addr[AW+1:2].
//   - An address is out of range when addr[ADDR_W-1:AW+2] != 0.
//   - An out-of-range access is still granted, but mem_en = 0 and the store is dropped.
//   - For D: d_rvalid (loads only) and d_err pulse at T+1, and d_rdata = 0.
//   - For I: i_rvalid pulses at T+1 with i_rdata = 0; there is no I error output.
//  Store: mem_wmask = d_wmask and mem_wdata = d_wdata at T. No d_rvalid. d_wmask == 0 is legal and writes nothing.
//  Load or fetch: mem_wmask = 0. The rvalid of the owning port pulses at T+1 and rdata = mem_rdata.
//  Response tracking:
//   - resp_owner is registered at T: NONE, I, D, or the ERR variants; there is no state for stores.
//   - The routing in T+1 depends only on resp_owner, so a new grant in T+1 is allowed (throughput 1 access/cycle).
//   - rdata is 0 whenever the matching rvalid is 0.
//  Request rule: once the requester sees gnt, it may drop or change req in the next cycle.
//   - A request that is dropped before gnt is legal and leaves no state behind.
//  Reset asserted mid-operation: a pending response is discarded (no rvalid after reset); rr_last returns to I.
// STRUCTURE
//  Package femto_mem_pkg holds:
//   - MEM_DEPTH_DEFAULT
//   - the owner encoding: OWN_NONE, OWN_I, OWN_D, OWN_I_ERR, OWN_D_ERR
//   - WMASK_NONE / WMASK_WORD constants
//  Sub-module rr_arb2 (req[1:0], last pointer -> one-hot grant) holds the pick logic.
//  The top level holds the address mux, range check, resp_owner register and response routing.
// TESTING
//  1 Reset low for 3 cycles, then high, no requests -> all outputs stay 0 for 5 cycles.
//  2 Preload word 4 = 0x00100093; i_req with i_addr = 0x10 -> i_gnt @T, mem_addr = 4, then @T+1 i_rvalid = 1 and i_rdata = 0x00100093.
//  3 i_req and d_req both high from the first cycle after reset, each held until its grant -> d_gnt @T, i_gnt @T+1, d_rvalid @T+1, i_rvalid @T+2; never two gnts in one cycle.
//  4 Store with d_addr = 0x20, d_wmask = 0011, d_wdata = 0xDEADBEEF over word 0xFFFFFFFF -> mem_wmask = 0011, no d_rvalid. A load of 0x20 then returns 0xFFFFBEEF.
//  5 MEM_DEPTH = 256, d_req load at d_addr = 0x400 -> d_gnt, mem_en = 0; @T+1 d_rvalid = 1, d_err = 1, d_rdata = 0.
//  6 Both requests held high continuously for 8 cycles -> grants alternate D,I,D,I,...; reset pulsed in the cycle after a grant -> no rvalid, and D wins the next tie.

Source files
------------

// File: rtl/femto_mem_pkg.sv
// Shared types and constants for the instruction/data memory port arbiter.
// Holds the response-owner encoding, the port identifiers used by the
// round-robin pointer, write-mask constants and small address helpers.
package femto_mem_pkg;

  // Default memory size in 32-bit words (must be a power of two).
  localparam int MEM_DEPTH_DEFAULT = 256;

  // Default requester byte-address width.
  localparam int ADDR_W_DEFAULT = 32;

  // Data path width and byte-lane count.
  localparam int WORD_W = 32;
  localparam int MASK_W = WORD_W / 8;

  // Write-mask constants: no bytes written (a read) / all four bytes written.
  localparam logic [MASK_W-1:0] WMASK_NONE = 4'b0000;
  localparam logic [MASK_W-1:0] WMASK_WORD = 4'b1111;

  // Requester identity; the round-robin pointer remembers the last winner.
  typedef enum logic {
    PORT_I = 1'b0,
    PORT_D = 1'b1
  } port_e;

  // Who owns the response returning in the cycle after a grant.
  // Stores have no response, so they never occupy an owner state.
  typedef enum logic [2:0] {
    OWN_NONE  = 3'd0,
    OWN_I     = 3'd1,
    OWN_D     = 3'd2,
    OWN_I_ERR = 3'd3,
    OWN_D_ERR = 3'd4
  } owner_e;

  // Owner tag for a read access issued by the given port.
  function automatic owner_e read_owner(input port_e port, input logic out_of_range);
    owner_e own;
    if (port == PORT_I) begin
      own = out_of_range ? OWN_I_ERR : OWN_I;
    end else begin
      own = out_of_range ? OWN_D_ERR : OWN_D;
    end
    return own;
  endfunction

  // True when the owner tag carries valid read data from the memory.
  function automatic logic owner_has_data(input owner_e own);
    return (own == OWN_I) || (own == OWN_D);
  endfunction

endpackage : femto_mem_pkg

// File: rtl/mem_port_arbiter_if.sv
// Bundle of the fetch port, the load/store port and the memory-side port of
// the arbiter. The slave modport is the arbiter's view; the master modport is
// the view of the surrounding system (core requesters plus the block RAM).
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int AW     = 8
);

  // Instruction-fetch port.
  logic              i_req;
  logic [ADDR_W-1:0] i_addr;
  logic              i_gnt;
  logic              i_rvalid;
  logic [31:0]       i_rdata;

  // Load/store port.
  logic              d_req;
  logic              d_we;
  logic [3:0]        d_wmask;
  logic [ADDR_W-1:0] d_addr;
  logic [31:0]       d_wdata;
  logic              d_gnt;
  logic              d_rvalid;
  logic [31:0]       d_rdata;
  logic              d_err;

  // Memory port.
  logic              mem_en;
  logic [3:0]        mem_wmask;
  logic [AW-1:0]     mem_addr;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;

  modport slave (
    input  i_req, i_addr,
    output i_gnt, i_rvalid, i_rdata,
    input  d_req, d_we, d_wmask, d_addr, d_wdata,
    output d_gnt, d_rvalid, d_rdata, d_err,
    output mem_en, mem_wmask, mem_addr, mem_wdata,
    input  mem_rdata
  );

  modport master (
    output i_req, i_addr,
    input  i_gnt, i_rvalid, i_rdata,
    output d_req, d_we, d_wmask, d_addr, d_wdata,
    input  d_gnt, d_rvalid, d_rdata, d_err,
    input  mem_en, mem_wmask, mem_addr, mem_wdata,
    output mem_rdata
  );

endinterface : mem_port_arbiter_if

// File: rtl/rr_arb2.sv
// Two-way round-robin pick. Bit 0 is the fetch port, bit 1 the load/store
// port. A lone requester always wins; on a tie the port that did not win
// last time is chosen. Purely combinational; the pointer lives in the top.
module rr_arb2
  import femto_mem_pkg::*;
(
  input  logic [1:0] req_i,
  input  port_e      last_i,
  output logic [1:0] gnt_o
);

  // One-hot grant from the request pair and the last-winner pointer.
  always_comb begin
    // NOTE: every always_comb output gets a default before any branch, so no path leaves it unassigned and no latch is inferred.
    gnt_o = 2'b00;
    case (req_i)
      2'b01:   gnt_o = 2'b01;
      2'b10:   gnt_o = 2'b10;
      2'b11:   gnt_o = (last_i == PORT_I) ? 2'b10 : 2'b01;
      default: gnt_o = 2'b00;
    endcase
  end

endmodule : rr_arb2

// File: rtl/mem_port_arbiter.sv
// Shares one synchronous word memory between the fetch port (I) and the
// load/store port (D). One access is issued per cycle, picked round-robin.
// The grant and the memory request are combinational from the requests;
// read data comes back one cycle later and is steered by a registered owner
// tag, so a new grant may be issued in the same cycle as a response.
module mem_port_arbiter
  import femto_mem_pkg::*;
#(
  parameter int MEM_DEPTH = MEM_DEPTH_DEFAULT,
  parameter int ADDR_W    = ADDR_W_DEFAULT,
  localparam int AW       = $clog2(MEM_DEPTH)
) (
  input  logic                clk,
  input  logic                reset,
  mem_port_arbiter_if.slave   bus
);

  // Arbitration signals.
  logic [1:0]        arb_req;
  logic [1:0]        arb_gnt;
  logic              gnt_i;
  logic              gnt_d;
  logic              any_gnt;

  // Selected address and its decode.
  logic [ADDR_W-1:0] sel_addr;
  logic [AW-1:0]     word_idx;
  logic              out_of_range;
  logic              is_store;
  logic              unused_addr_lsbs;

  // Registered state.
  port_e             rr_last_q;
  port_e             rr_last_d;
  owner_e            resp_owner_q;
  owner_e            resp_owner_d;
  logic              st_err_q;
  logic              st_err_d;

  // Requests are masked while reset is held so that every output is 0 in reset.
  assign arb_req = {bus.d_req & reset, bus.i_req & reset};

  rr_arb2 u_rr_arb2 (
    .req_i  (arb_req),
    .last_i (rr_last_q),
    .gnt_o  (arb_gnt)
  );

  assign gnt_i   = arb_gnt[0];
  assign gnt_d   = arb_gnt[1];
  assign any_gnt = |arb_gnt;

  // Address mux and range check for the port being granted this cycle.
  always_comb begin
    sel_addr     = gnt_d ? bus.d_addr : bus.i_addr;
    word_idx     = sel_addr[AW+1:2];
    out_of_range = |sel_addr[ADDR_W-1:AW+2];
  end

  // The byte offset inside a word never reaches the memory.
  assign unused_addr_lsbs = ^sel_addr[1:0];

  // Grants and the memory request issued this cycle.
  always_comb begin
    bus.i_gnt     = gnt_i;
    bus.d_gnt     = gnt_d;
    is_store      = gnt_d & bus.d_we & ~out_of_range;
    bus.mem_en    = any_gnt & ~out_of_range;
    bus.mem_addr  = any_gnt ? word_idx : '0;
    bus.mem_wmask = is_store ? (bus.d_wmask & WMASK_WORD) : WMASK_NONE;
    bus.mem_wdata = is_store ? bus.d_wdata : '0;
  end

  // Next round-robin pointer and the owner of next cycle's response.
  always_comb begin
    rr_last_d    = rr_last_q;
    resp_owner_d = OWN_NONE;
    st_err_d     = 1'b0;
    if (gnt_i) begin
      rr_last_d    = PORT_I;
      resp_owner_d = read_owner(PORT_I, out_of_range);
    end else if (gnt_d) begin
      rr_last_d = PORT_D;
      if (bus.d_we) begin
        // A store only needs a follow-up cycle to flag a dropped write.
        st_err_d = out_of_range;
      end else begin
        resp_owner_d = read_owner(PORT_D, out_of_range);
      end
    end
  end

  // State registers; reset discards any pending response and re-arms D for the first tie.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rr_last_q    <= PORT_I;
      resp_owner_q <= OWN_NONE;
      st_err_q     <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignment so every register samples pre-edge values.
      rr_last_q    <= rr_last_d;
      resp_owner_q <= resp_owner_d;
      st_err_q     <= st_err_d;
    end
  end

  // Response routing, driven only by the registered owner tag.
  always_comb begin
    bus.i_rvalid = 1'b0;
    bus.i_rdata  = '0;
    bus.d_rvalid = 1'b0;
    bus.d_rdata  = '0;
    bus.d_err    = st_err_q;
    case (resp_owner_q)
      OWN_I: begin
        bus.i_rvalid = 1'b1;
        bus.i_rdata  = owner_has_data(resp_owner_q) ? bus.mem_rdata : '0;
      end
      OWN_I_ERR: begin
        bus.i_rvalid = 1'b1;
      end
      OWN_D: begin
        bus.d_rvalid = 1'b1;
        bus.d_rdata  = owner_has_data(resp_owner_q) ? bus.mem_rdata : '0;
      end
      OWN_D_ERR: begin
        bus.d_rvalid = 1'b1;
        bus.d_err    = 1'b1;
      end
      default: begin
        bus.i_rvalid = 1'b0;
      end
    endcase
  end

endmodule : mem_port_arbiter

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: a block-RAM model on the memory
// side, directed scenarios with literal expectations, then randomized
// requester traffic compared every cycle against a behavioural model.
module tb_mem_port_arbiter;

  localparam int MEM_DEPTH = 256;
  localparam int ADDR_W    = 32;
  localparam int AW        = 8;

  logic clk;
  logic rst_n;

  int n_cmp = 0;
  int n_err = 0;

  mem_port_arbiter_if #(.ADDR_W(ADDR_W), .AW(AW)) bus ();

  mem_port_arbiter #(.MEM_DEPTH(MEM_DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk   (clk),
    .reset (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Block RAM on the memory side (synchronous read, byte-write).
  logic [31:0] ram [MEM_DEPTH];
  logic [31:0] ram_rdata;
  assign bus.mem_rdata = ram_rdata;

  always @(posedge clk) begin
    if (bus.mem_en) begin
      if (bus.mem_wmask == 4'b0000) begin
        ram_rdata <= ram[bus.mem_addr];
      end else begin
        for (int b = 0; b < 4; b++) begin
          if (bus.mem_wmask[b]) ram[bus.mem_addr][8*b +: 8] <= bus.d_wdata[8*b +: 8];
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      if (n_err <= 40) $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural reference model ----------------
  logic [31:0] shadow [MEM_DEPTH];
  int          m_last;            // 0 = I won last, 1 = D won last
  logic        m_i_v, m_d_v, m_d_e;
  logic [31:0] m_i_d, m_d_d;

  int          g;                 // -1 none, 0 I, 1 D
  logic [31:0] a;
  logic        oor;
  int          widx;
  logic [31:0] exp_wdata;
  logic [3:0]  exp_wmask;
  logic [31:0] wr;

  always @(negedge clk) begin
    if (!rst_n) begin
      m_last = 0;
      m_i_v = 0; m_d_v = 0; m_d_e = 0; m_i_d = 0; m_d_d = 0;
      check("rst_gnts",   {bus.i_gnt, bus.d_gnt, bus.mem_en}, 0);
      check("rst_resp",   {bus.i_rvalid, bus.d_rvalid, bus.d_err}, 0);
      check("rst_rdata",  bus.i_rdata | bus.d_rdata, 0);
      check("rst_memsig", {bus.mem_wmask, bus.mem_addr} | bus.mem_wdata, 0);
    end else begin
      check("i_rvalid", bus.i_rvalid, m_i_v);
      check("i_rdata",  bus.i_rdata,  m_i_d);
      check("d_rvalid", bus.d_rvalid, m_d_v);
      check("d_rdata",  bus.d_rdata,  m_d_d);
      check("d_err",    bus.d_err,    m_d_e);

      if (bus.i_req && bus.d_req) g = (m_last == 0) ? 1 : 0;
      else if (bus.d_req)         g = 1;
      else if (bus.i_req)         g = 0;
      else                        g = -1;

      a    = (g == 1) ? bus.d_addr : bus.i_addr;
      oor  = (a >> (AW + 2)) != 0;
      widx = int'((a >> 2) % MEM_DEPTH);
      exp_wmask = (g == 1 && bus.d_we && !oor) ? bus.d_wmask : 4'b0000;
      exp_wdata = (g == 1 && bus.d_we && !oor) ? bus.d_wdata : 32'h0;

      check("i_gnt",     bus.i_gnt, g == 0);
      check("d_gnt",     bus.d_gnt, g == 1);
      check("mem_en",    bus.mem_en, (g >= 0) && !oor);
      check("mem_addr",  bus.mem_addr, (g >= 0) ? widx : 0);
      check("mem_wmask", bus.mem_wmask, exp_wmask);
      check("mem_wdata", bus.mem_wdata, exp_wdata);

      // Response expected in the next cycle.
      m_i_v = 0; m_d_v = 0; m_d_e = 0; m_i_d = 0; m_d_d = 0;
      if (g == 0) begin
        m_i_v = 1;
        m_i_d = oor ? 32'h0 : shadow[widx];
      end else if (g == 1) begin
        if (bus.d_we) begin
          m_d_e = oor;
          if (!oor) begin
            wr = shadow[widx];
            for (int b = 0; b < 4; b++) if (bus.d_wmask[b]) wr[8*b +: 8] = bus.d_wdata[8*b +: 8];
            shadow[widx] = wr;
          end
        end else begin
          m_d_v = 1;
          m_d_e = oor;
          m_d_d = oor ? 32'h0 : shadow[widx];
        end
      end
      if (g >= 0) m_last = g;
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] rand_addr();
    logic [31:0] r;
    r = $urandom;
    if ($urandom_range(0, 9) != 0) r[31:10] = '0;
    else r[10] = 1'b1;
    return r;
  endfunction

  int  grant_d_cnt;
  bit  i_pend, d_pend;

  initial begin
    rst_n = 1'b1;
    bus.i_req = 0; bus.i_addr = 0;
    bus.d_req = 0; bus.d_we = 0; bus.d_wmask = 0; bus.d_addr = 0; bus.d_wdata = 0;
    ram_rdata = 32'h0;
    for (int k = 0; k < MEM_DEPTH; k++) begin
      ram[k]    = (k * 32'h01010101) ^ 32'hA5A5_0000;
      shadow[k] = (k * 32'h01010101) ^ 32'hA5A5_0000;
    end
    ram[4] = 32'h00100093; shadow[4] = 32'h00100093;
    ram[8] = 32'hFFFFFFFF; shadow[8] = 32'hFFFFFFFF;
    #1 rst_n = 1'b0;

    // 1: reset for 3 cycles, then idle outputs stay 0.
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("idle_zero", {bus.i_gnt, bus.d_gnt, bus.i_rvalid, bus.d_rvalid, bus.d_err, bus.mem_en}, 0);
      step();
    end

    // 2: fetch from 0x10 returns word 4.
    bus.i_req = 1; bus.i_addr = 32'h10;
    @(negedge clk);
    check("t2_i_gnt", bus.i_gnt, 1);
    check("t2_mem_addr", bus.mem_addr, 4);
    step();
    bus.i_req = 0;
    @(negedge clk);
    check("t2_i_rvalid", bus.i_rvalid, 1);
    check("t2_i_rdata", bus.i_rdata, 32'h00100093);
    step();

    // 3: simultaneous requests straight out of reset.
    rst_n = 0;
    step();
    rst_n = 1;
    bus.i_req = 1; bus.i_addr = 32'h10;
    bus.d_req = 1; bus.d_we = 0; bus.d_addr = 32'h20;
    @(negedge clk);
    check("t3_gnt_T", {bus.d_gnt, bus.i_gnt}, 2'b10);
    step();
    bus.d_req = 0;
    @(negedge clk);
    check("t3_gnt_T1", {bus.d_gnt, bus.i_gnt}, 2'b01);
    check("t3_d_rvalid", bus.d_rvalid, 1);
    step();
    bus.i_req = 0;
    @(negedge clk);
    check("t3_i_rvalid", bus.i_rvalid, 1);
    step();

    // 4: partial store then load-back.
    bus.d_req = 1; bus.d_we = 1; bus.d_addr = 32'h20; bus.d_wmask = 4'b0011; bus.d_wdata = 32'hDEADBEEF;
    @(negedge clk);
    check("t4_wmask", bus.mem_wmask, 4'b0011);
    check("t4_wdata", bus.mem_wdata, 32'hDEADBEEF);
    step();
    bus.d_we = 0;
    @(negedge clk);
    check("t4_no_rvalid", bus.d_rvalid, 0);
    step();
    bus.d_req = 0;
    @(negedge clk);
    check("t4_load_back", bus.d_rdata, 32'hFFFFBEEF);
    step();

    // 5: out-of-range load.
    bus.d_req = 1; bus.d_we = 0; bus.d_addr = 32'h400;
    @(negedge clk);
    check("t5_gnt_en", {bus.d_gnt, bus.mem_en}, 2'b10);
    step();
    bus.d_req = 0;
    @(negedge clk);
    check("t5_resp", {bus.d_rvalid, bus.d_err}, 2'b11);
    check("t5_rdata", bus.d_rdata, 0);
    step();

    // 6: continuous contention alternates; reset after a D grant.
    rst_n = 0;
    step();
    rst_n = 1;
    bus.i_req = 1; bus.i_addr = 32'h14;
    bus.d_req = 1; bus.d_we = 0; bus.d_addr = 32'h24;
    for (int k = 0; k < 9; k++) begin
      @(negedge clk);
      check("t6_alternate", {bus.d_gnt, bus.i_gnt}, (k % 2 == 0) ? 2'b10 : 2'b01);
      step();
    end
    rst_n = 0;
    @(negedge clk);
    check("t6_no_rvalid", {bus.i_rvalid, bus.d_rvalid}, 0);
    step();
    rst_n = 1;
    @(negedge clk);
    check("t6_d_wins", {bus.d_gnt, bus.i_gnt}, 2'b10);
    step();
    bus.i_req = 0; bus.d_req = 0;
    step();

    // Randomized traffic checked by the model every cycle.
    i_pend = 0; d_pend = 0; grant_d_cnt = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (!rst_n) rst_n = 1;
      else if ($urandom_range(0, 249) == 0) begin
        rst_n = 0; i_pend = 0; d_pend = 0;
      end
      if (i_pend && $urandom_range(0, 15) == 0) begin
        bus.i_req = 0; i_pend = 0;
      end else if (!i_pend) begin
        bus.i_req  = ($urandom_range(0, 99) < 55);
        bus.i_addr = rand_addr();
        i_pend = bus.i_req;
      end
      if (d_pend && $urandom_range(0, 15) == 0) begin
        bus.d_req = 0; d_pend = 0;
      end else if (!d_pend) begin
        bus.d_req   = ($urandom_range(0, 99) < 55);
        bus.d_addr  = rand_addr();
        bus.d_we    = ($urandom_range(0, 2) == 0);
        bus.d_wmask = 4'($urandom_range(0, 15));
        bus.d_wdata = $urandom;
        d_pend = bus.d_req;
      end
      @(negedge clk);
      if (bus.i_gnt) i_pend = 0;
      if (bus.d_gnt) begin
        d_pend = 0;
        grant_d_cnt++;
      end
      step();
    end
    bus.i_req = 0; bus.d_req = 0;
    repeat (2) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_mem_port_arbiter
